// File: rtl/register_file.sv
// register_file: bank of 2^ADDR_W general-purpose registers for the CPU datapath.
// Two combinational read ports, one clocked write port, and a hardware clear
// sweep that zeroes one register per cycle while outBusy is high.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write to a
// read port addressing the same register in the same cycle.
module register_file #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              inClk,
    input  logic              inReset,
    input  logic              inWriteEn,
    input  logic [ADDR_W-1:0] inWriteAddr,
    input  logic [WIDTH-1:0]  inWriteData,
    input  logic [ADDR_W-1:0] inReadAddrA,
    input  logic [ADDR_W-1:0] inReadAddrB,
    output logic [WIDTH-1:0]  outReadA,
    output logic [WIDTH-1:0]  outReadB,
    input  logic              inClear,
    output logic              outBusy,
    output logic              outWriteAck
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic              busy;
    logic              write_ack;
    logic              accept_write;
    logic [WIDTH-1:0]  regs [DEPTH];

    // A write is only stored from IDLE, and a simultaneous clear request wins.
    assign accept_write = (state == IDLE) && !inClear && inWriteEn;

    // Control FSM: sweep sequencing, registered busy decode and write acknowledge.
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            write_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (inClear) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        write_ack <= 1'b0;
                    end else begin
                        write_ack <= inWriteEn;
                    end
                end
                SWEEP: begin
                    write_ack <= 1'b0;
                    if (counter == ADDR_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    counter   <= '0;
                    write_ack <= 1'b0;
                end
            endcase
        end
    end

    assign outBusy     = busy;
    assign outWriteAck = write_ack;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        logic [WIDTH-1:0] q;
        logic             sweep_hit;
        logic             write_hit;

        assign sweep_hit = (state == SWEEP) && (counter == ADDR_W'(i));
        assign write_hit = accept_write && (inWriteAddr == ADDR_W'(i));

        // Storage flops for one register: sweep clear has priority over a write.
        always_ff @(posedge inClk or posedge inReset) begin
            if (inReset) begin
                q <= '0;
            end else if (sweep_hit) begin
                q <= '0;
            end else if (write_hit) begin
                q <= inWriteData;
            end
        end

        assign regs[i] = q;
    end

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of an accepted write to a matching read port.
    assign outReadA = (accept_write && (inReadAddrA == inWriteAddr)) ? inWriteData : regs[inReadAddrA];
    assign outReadB = (accept_write && (inReadAddrB == inWriteAddr)) ? inWriteData : regs[inReadAddrB];
`else
    // Read ports show stored contents only; a same-cycle write is seen next cycle.
    assign outReadA = regs[inReadAddrA];
    assign outReadB = regs[inReadAddrB];
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table-driven write/read vectors with a
// write-acknowledge scoreboard, plus hand sequences for reset, bypass and sweeps.
`timescale 1ns/1ps
module tb_register_file;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

`ifdef REGFILE_BYPASS_EN
    localparam logic [WIDTH-1:0] BYP_EXP = 8'h3C;
`else
    localparam logic [WIDTH-1:0] BYP_EXP = 8'h11;
`endif

    logic              inClk = 1'b0;
    logic              inReset;
    logic              inWriteEn;
    logic [ADDR_W-1:0] inWriteAddr;
    logic [WIDTH-1:0]  inWriteData;
    logic [ADDR_W-1:0] inReadAddrA;
    logic [ADDR_W-1:0] inReadAddrB;
    logic [WIDTH-1:0]  outReadA;
    logic [WIDTH-1:0]  outReadB;
    logic              inClear;
    logic              outBusy;
    logic              outWriteAck;

    register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .inClk       (inClk),
        .inReset     (inReset),
        .inWriteEn   (inWriteEn),
        .inWriteAddr (inWriteAddr),
        .inWriteData (inWriteData),
        .inReadAddrA (inReadAddrA),
        .inReadAddrB (inReadAddrB),
        .outReadA    (outReadA),
        .outReadB    (outReadB),
        .inClear     (inClear),
        .outBusy     (outBusy),
        .outWriteAck (outWriteAck)
    );

    always #10 inClk = ~inClk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [WIDTH-1:0]  wd;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [WIDTH-1:0]  ea;
        logic [WIDTH-1:0]  eb;
    } vec_t;

    vec_t vecs [8];
    int   passed = 0;
    int   total  = 0;
    logic ack_q [$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_in(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd, input logic clr);
        inWriteEn   = we;
        inWriteAddr = wa;
        inWriteData = wd;
        inClear     = clr;
    endtask

    // One clock: the expected ack is queued, then popped and compared after the edge.
    task automatic cyc(input logic exp_ack);
        logic e;
        ack_q.push_back(exp_ack);
        @(posedge inClk);
        #1;
        e = ack_q.pop_front();
        check("write_ack", outWriteAck, e);
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        set_in(1'b1, a, d, 1'b0);
        cyc(1'b1);
        set_in(1'b0, '0, '0, 1'b0);
    endtask

    task automatic read_chk(input string name, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] ea,
                            input logic [ADDR_W-1:0] b, input logic [WIDTH-1:0] eb);
        inReadAddrA = a;
        inReadAddrB = b;
        #1;
        check({name, "_A"}, outReadA, ea);
        check({name, "_B"}, outReadB, eb);
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            inReadAddrA = ADDR_W'(i);
            inReadAddrB = ADDR_W'(DEPTH - 1 - i);
            #1;
            check({name, "_A"}, outReadA, 8'h00);
            check({name, "_B"}, outReadB, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd5, 3'd6, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 3'd6, 8'h5A, 3'd3, 3'd0, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd6, 8'hA5, 8'h5A};
        vecs[3] = '{1'b1, 3'd0, 8'h01, 3'd6, 3'd3, 8'h5A, 8'hA5};
        vecs[4] = '{1'b1, 3'd0, 8'h02, 3'd7, 3'd1, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h02, 8'h02};
        vecs[6] = '{1'b1, 3'd7, 8'hFF, 3'd5, 3'd4, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd3, 8'hFF, 8'hA5};

        inReset = 1'b1;
        set_in(1'b0, '0, '0, 1'b0);
        inReadAddrA = '0;
        inReadAddrB = '0;
        #25;
        inReset = 1'b0;

        // Random prior contents, then an asynchronous reset in mid-cycle.
        for (int i = 0; i < DEPTH; i++) write_reg(ADDR_W'(i), 8'($urandom_range(1, 255)));
        #3;
        inReset = 1'b1;
        #1;
        check("reset_busy", outBusy, 1'b0);
        check("reset_ack", outWriteAck, 1'b0);
        chk_all_zero("reset_read");
        inReset = 1'b0;
        cyc(1'b0);

        // Table-driven write/read vectors; reads are sampled before each edge.
        for (int k = 0; k < 8; k++) begin
            set_in(vecs[k].we, vecs[k].wa, vecs[k].wd, 1'b0);
            read_chk($sformatf("vec%0d", k), vecs[k].ra, vecs[k].ea, vecs[k].rb, vecs[k].eb);
            cyc(vecs[k].we);
        end
        set_in(1'b0, '0, '0, 1'b0);

        // Same-cycle read of the register being written.
        write_reg(3'd2, 8'h11);
        set_in(1'b1, 3'd2, 8'h3C, 1'b0);
        inReadAddrA = 3'd2;
        #1;
        check("bypass_same_cycle", outReadA, BYP_EXP);
        cyc(1'b1);
        set_in(1'b0, '0, '0, 1'b0);
        read_chk("bypass_next", 3'd2, 8'h3C, 3'd2, 8'h3C);

        // Clear sweep over a filled bank.
        for (int i = 0; i < DEPTH; i++) write_reg(ADDR_W'(i), 8'(8'h10 + i));
        set_in(1'b0, '0, '0, 1'b1);
        cyc(1'b0);
        set_in(1'b0, '0, '0, 1'b0);
        check("sweep_busy_start", outBusy, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        read_chk("sweep_partial", 3'd5, 8'h15, 3'd3, 8'h00);
        check("sweep_busy_mid", outBusy, 1'b1);
        n = 5;
        while (outBusy && n < 20) begin
            cyc(1'b0);
            if (outBusy) n++;
        end
        check("sweep_busy_len", 8'(n), 8'd8);
        chk_all_zero("after_sweep");

        // Clear and write together in IDLE, then writes while busy.
        write_reg(3'd1, 8'h33);
        set_in(1'b1, 3'd1, 8'hFF, 1'b1);
        inReadAddrA = 3'd1;
        #1;
        check("no_bypass_on_clear", outReadA, 8'h33);
        cyc(1'b0);
        set_in(1'b0, '0, '0, 1'b0);
        check("contention_busy", outBusy, 1'b1);
        cyc(1'b0);
        cyc(1'b0);
        set_in(1'b1, 3'd0, 8'hEE, 1'b0);
        inReadAddrA = 3'd0;
        #1;
        check("no_bypass_in_sweep", outReadA, 8'h00);
        cyc(1'b0);
        set_in(1'b1, 3'd1, 8'hFF, 1'b0);
        cyc(1'b0);
        set_in(1'b0, '0, '0, 1'b0);
        n = 0;
        while (outBusy && n < 20) begin
            cyc(1'b0);
            n++;
        end
        check("sweep2_done", outBusy, 1'b0);
        read_chk("dropped_writes", 3'd0, 8'h00, 3'd1, 8'h00);

        // Reset in the middle of a sweep.
        write_reg(3'd7, 8'h42);
        write_reg(3'd6, 8'h24);
        set_in(1'b0, '0, '0, 1'b1);
        cyc(1'b0);
        set_in(1'b0, '0, '0, 1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("mid_sweep_busy", outBusy, 1'b1);
        #2;
        inReset = 1'b1;
        #1;
        check("mid_reset_busy", outBusy, 1'b0);
        chk_all_zero("mid_reset_read");
        inReset = 1'b0;
        cyc(1'b0);
        check("no_resume", outBusy, 1'b0);
        write_reg(3'd7, 8'h77);
        read_chk("post_reset_write", 3'd7, 8'h77, 3'd6, 8'h00);
        check("post_reset_idle", outBusy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
